// File: rtl/naive_bus_rr_router.sv
// naive_bus_rr_router: N masters to N slaves, one request-address-data bus
// per slave, arbitrated per slave (fixed priority or round-robin). Decode
// misses complete locally with gnt=1 and read data 0, and are counted.
module naive_bus_rr_router #(
    parameter int                      N_MASTER    = 3,
    parameter int                      N_SLAVE     = 5,
    parameter logic [N_SLAVE*32-1:0]   SLAVES_MASK = {32'h3, 32'hfff, 32'hfff, 32'hfff, 32'hfff},
    parameter logic [N_SLAVE*32-1:0]   SLAVES_BASE = {32'h30000, 32'h20000, 32'h10000, 32'h8000, 32'h0},
    parameter int                      ARB_MODE    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_MASTER-1:0]       m_rd_req,
    input  logic [N_MASTER-1:0]       m_wr_req,
    output logic [N_MASTER-1:0]       m_rd_gnt,
    output logic [N_MASTER-1:0]       m_wr_gnt,
    input  logic [N_MASTER*32-1:0]    m_rd_addr,
    input  logic [N_MASTER*32-1:0]    m_wr_addr,
    input  logic [N_MASTER*32-1:0]    m_wr_data,
    input  logic [N_MASTER*4-1:0]     m_wr_be,
    output logic [N_MASTER*32-1:0]    m_rd_data,
    output logic [N_SLAVE-1:0]        s_rd_req,
    output logic [N_SLAVE-1:0]        s_wr_req,
    input  logic [N_SLAVE-1:0]        s_rd_gnt,
    input  logic [N_SLAVE-1:0]        s_wr_gnt,
    output logic [N_SLAVE*32-1:0]     s_rd_addr,
    output logic [N_SLAVE*32-1:0]     s_wr_addr,
    output logic [N_SLAVE*32-1:0]     s_wr_data,
    output logic [N_SLAVE*4-1:0]      s_wr_be,
    input  logic [N_SLAVE*32-1:0]     s_rd_data,
    output logic [15:0]               dec_err_cnt
);
    localparam int MW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
    localparam int SW = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;
    localparam logic [MW-1:0] LAST_M = MW'(N_MASTER - 1);

    logic [N_MASTER-1:0]               op_rd, op_wr, tgt_hit, err_hit;
    logic [N_MASTER-1:0][SW-1:0]       tgt_idx;
    logic [N_MASTER-1:0][31:0]         tgt_addr;
    logic [N_SLAVE-1:0][N_MASTER-1:0]  req_mat;
    logic [N_SLAVE-1:0]                sel_vld, sel_rd, sel_wr, slv_gnt, locked;
    logic [N_SLAVE-1:0][MW-1:0]        sel_idx, lock_idx, ptr;
    logic [N_MASTER-1:0]               rd_pend, rd_err;
    logic [N_MASTER-1:0][SW-1:0]       rd_src;
    logic [16:0]                       err_sum;

    // Per master: pick the active operation (read wins) and decode its address.
    // Scanning downward lets the lowest matching slave overwrite the result.
    always_comb begin
        for (int m = 0; m < N_MASTER; m++) begin
            op_rd[m]    = m_rd_req[m];
            op_wr[m]    = !m_rd_req[m] && m_wr_req[m];
            tgt_addr[m] = op_rd[m] ? m_rd_addr[32*m +: 32] : m_wr_addr[32*m +: 32];
            tgt_hit[m]  = 1'b0;
            tgt_idx[m]  = '0;
            for (int s = N_SLAVE - 1; s >= 0; s--) begin
                if ((tgt_addr[m] & ~SLAVES_MASK[32*s +: 32]) == SLAVES_BASE[32*s +: 32]) begin
                    tgt_hit[m] = 1'b1;
                    tgt_idx[m] = SW'(s);
                end
            end
        end
    end

    // Request matrix: which masters want which slave this cycle.
    always_comb begin
        for (int s = 0; s < N_SLAVE; s++)
            for (int m = 0; m < N_MASTER; m++)
                req_mat[s][m] = (op_rd[m] || op_wr[m]) && tgt_hit[m] && (tgt_idx[m] == SW'(s));
    end

    // Per-slave selection: a still-requesting locked master keeps the slave,
    // otherwise search from ptr (round-robin) or from master 0 (fixed).
    always_comb begin
        int cand;
        cand = 0;
        for (int s = 0; s < N_SLAVE; s++) begin
            sel_vld[s] = 1'b0;
            sel_idx[s] = '0;
            if (locked[s] && req_mat[s][lock_idx[s]]) begin
                sel_vld[s] = 1'b1;
                sel_idx[s] = lock_idx[s];
            end else begin
                for (int off = 0; off < N_MASTER; off++) begin
                    cand = (ARB_MODE == 1) ? int'(ptr[s]) + off : off;
                    if (cand >= N_MASTER) cand = cand - N_MASTER;
                    if (!sel_vld[s] && req_mat[s][cand]) begin
                        sel_vld[s] = 1'b1;
                        sel_idx[s] = MW'(cand);
                    end
                end
            end
        end
    end

    // Route the selected master onto each slave bus and return the slave's
    // grant to that master only; decode misses are granted locally.
    always_comb begin
        s_rd_req  = '0;
        s_wr_req  = '0;
        s_rd_addr = '0;
        s_wr_addr = '0;
        s_wr_data = '0;
        s_wr_be   = '0;
        m_rd_gnt  = '0;
        m_wr_gnt  = '0;
        slv_gnt   = '0;
        err_hit   = '0;
        for (int s = 0; s < N_SLAVE; s++) begin
            sel_rd[s] = sel_vld[s] && op_rd[sel_idx[s]];
            sel_wr[s] = sel_vld[s] && op_wr[sel_idx[s]];
            if (sel_rd[s]) begin
                s_rd_req[s]          = 1'b1;
                s_rd_addr[32*s +: 32] = m_rd_addr[32*sel_idx[s] +: 32];
                m_rd_gnt[sel_idx[s]] = s_rd_gnt[s];
            end
            if (sel_wr[s]) begin
                s_wr_req[s]           = 1'b1;
                s_wr_addr[32*s +: 32] = m_wr_addr[32*sel_idx[s] +: 32];
                s_wr_data[32*s +: 32] = m_wr_data[32*sel_idx[s] +: 32];
                s_wr_be[4*s +: 4]     = m_wr_be[4*sel_idx[s] +: 4];
                m_wr_gnt[sel_idx[s]]  = s_wr_gnt[s];
            end
            slv_gnt[s] = (sel_rd[s] && s_rd_gnt[s]) || (sel_wr[s] && s_wr_gnt[s]);
        end
        for (int m = 0; m < N_MASTER; m++) begin
            if ((op_rd[m] || op_wr[m]) && !tgt_hit[m]) begin
                err_hit[m] = 1'b1;
                if (op_rd[m]) m_rd_gnt[m] = 1'b1;
                else          m_wr_gnt[m] = 1'b1;
            end
        end
        // Handshake outputs are held quiet for the whole reset window.
        if (!rst_n) begin
            s_rd_req = '0;
            s_wr_req = '0;
            m_rd_gnt = '0;
            m_wr_gnt = '0;
            slv_gnt  = '0;
            err_hit  = '0;
        end
    end

    // Pointer advances and lock releases only when the slave grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            locked   <= '0;
            lock_idx <= '0;
        end else begin
            for (int s = 0; s < N_SLAVE; s++) begin
                locked[s]   <= sel_vld[s] && !slv_gnt[s];
                lock_idx[s] <= sel_idx[s];
                if (slv_gnt[s])
                    ptr[s] <= (sel_idx[s] == LAST_M) ? '0 : sel_idx[s] + MW'(1);
            end
        end
    end

    // Remember which slave (or a decode miss) owes each master read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= '0;
            rd_err  <= '0;
            rd_src  <= '0;
        end else begin
            rd_pend <= m_rd_gnt;
            for (int m = 0; m < N_MASTER; m++) begin
                rd_err[m] <= !tgt_hit[m];
                rd_src[m] <= tgt_idx[m];
            end
        end
    end

    // Read data mux; zero unless a real slave read is pending.
    always_comb begin
        m_rd_data = '0;
        for (int m = 0; m < N_MASTER; m++)
            if (rd_pend[m] && !rd_err[m])
                m_rd_data[32*m +: 32] = s_rd_data[32*rd_src[m] +: 32];
    end

    // Sum of decode misses this cycle added to the counter.
    always_comb begin
        int k;
        k = 0;
        for (int m = 0; m < N_MASTER; m++) k = k + int'(err_hit[m]);
        err_sum = {1'b0, dec_err_cnt} + 17'(k);
    end

    // Saturating decode-error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          dec_err_cnt <= '0;
        else if (err_sum[16]) dec_err_cnt <= 16'hffff;
        else                 dec_err_cnt <= err_sum[15:0];
    end
endmodule

// File: tb/tb_naive_bus_rr_router.sv
// Directed bench: round-robin DUT and a fixed-priority DUT share stimulus.
module tb_naive_bus_rr_router;
    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    m_rd_req, m_wr_req;
    logic [95:0]   m_rd_addr, m_wr_addr, m_wr_data;
    logic [11:0]   m_wr_be;
    logic [4:0]    s_rd_gnt, s_wr_gnt;
    logic [159:0]  s_rd_data;

    logic [2:0]    m_rd_gnt, m_wr_gnt, fp_m_rd_gnt, fp_m_wr_gnt;
    logic [95:0]   m_rd_data, fp_m_rd_data;
    logic [4:0]    s_rd_req, s_wr_req, fp_s_rd_req, fp_s_wr_req;
    logic [159:0]  s_rd_addr, s_wr_addr, s_wr_data, fp_s_rd_addr, fp_s_wr_addr, fp_s_wr_data;
    logic [19:0]   s_wr_be, fp_s_wr_be;
    logic [15:0]   dec_err_cnt, fp_dec_err_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    naive_bus_rr_router #(.ARB_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_rd_req(m_rd_req), .m_wr_req(m_wr_req), .m_rd_gnt(m_rd_gnt), .m_wr_gnt(m_wr_gnt),
        .m_rd_addr(m_rd_addr), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_be(m_wr_be),
        .m_rd_data(m_rd_data),
        .s_rd_req(s_rd_req), .s_wr_req(s_wr_req), .s_rd_gnt(s_rd_gnt), .s_wr_gnt(s_wr_gnt),
        .s_rd_addr(s_rd_addr), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data), .s_wr_be(s_wr_be),
        .s_rd_data(s_rd_data), .dec_err_cnt(dec_err_cnt)
    );

    naive_bus_rr_router #(.ARB_MODE(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m_rd_req(m_rd_req), .m_wr_req(m_wr_req), .m_rd_gnt(fp_m_rd_gnt), .m_wr_gnt(fp_m_wr_gnt),
        .m_rd_addr(m_rd_addr), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_be(m_wr_be),
        .m_rd_data(fp_m_rd_data),
        .s_rd_req(fp_s_rd_req), .s_wr_req(fp_s_wr_req), .s_rd_gnt(s_rd_gnt), .s_wr_gnt(s_wr_gnt),
        .s_rd_addr(fp_s_rd_addr), .s_wr_addr(fp_s_wr_addr), .s_wr_data(fp_s_wr_data), .s_wr_be(fp_s_wr_be),
        .s_rd_data(s_rd_data), .dec_err_cnt(fp_dec_err_cnt)
    );

    // Slave read data pattern: slave index, marker byte, cycle tag.
    function automatic logic [31:0] sd(input int i, input int c);
        return {8'(i), 8'h5d, 16'(c)};
    endfunction

    task automatic set_sdata(input int c);
        for (int i = 0; i < 5; i++) s_rd_data[32*i +: 32] = sd(i, c);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        m_rd_req = '0; m_wr_req = '0;
        m_rd_addr = '0; m_wr_addr = '0; m_wr_data = '0; m_wr_be = '0;
        s_rd_data = '0;
        // Requests and slave grants already up while in reset.
        m_rd_req = 3'b101;
        m_rd_addr[0 +: 32]  = 32'h10004;
        m_rd_addr[64 +: 32] = 32'h10004;
        s_rd_gnt = 5'h1f;
        s_wr_gnt = 5'h1f;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_rd_gnt", 32'(m_rd_gnt), 32'h0);
        chk("rst_s_rd_req", 32'(s_rd_req), 32'h0);
        chk("rst_m_rd_data", m_rd_data[31:0] | m_rd_data[95:64], 32'h0);
        chk("rst_cnt", 32'(dec_err_cnt), 32'h0);

        // Masters 0 and 2 hammer slave 2: RR alternates, fixed keeps master 0.
        next_cycle();
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            set_sdata(c);
            @(negedge clk);
            chk($sformatf("rr_gnt_c%0d", c), 32'(m_rd_gnt), (c % 2 == 1) ? 32'h1 : 32'h4);
            chk($sformatf("rr_data0_c%0d", c), m_rd_data[0 +: 32], (c % 2 == 0) ? sd(2, c) : 32'h0);
            chk($sformatf("rr_data2_c%0d", c), m_rd_data[64 +: 32], (c > 1 && c % 2 == 1) ? sd(2, c) : 32'h0);
            chk($sformatf("fp_gnt_c%0d", c), 32'(fp_m_rd_gnt), 32'h1);
            chk($sformatf("fp_data0_c%0d", c), fp_m_rd_data[0 +: 32], (c > 1) ? sd(2, c) : 32'h0);
            chk($sformatf("fp_data2_c%0d", c), fp_m_rd_data[64 +: 32], 32'h0);
            if (c == 1) chk("rr_s2_addr", s_rd_addr[64 +: 32], 32'h10004);
            next_cycle();
        end
        m_rd_req = '0;
        set_sdata(5);
        @(negedge clk);
        chk("rr_tail_data2", m_rd_data[64 +: 32], sd(2, 5));
        chk("fp_tail_data0", fp_m_rd_data[0 +: 32], sd(2, 5));
        next_cycle();

        // Concurrent: master 1 writes slave 3 while master 2 reads slave 1.
        m_wr_req = 3'b010;
        m_wr_addr[32 +: 32] = 32'h20010;
        m_wr_data[32 +: 32] = 32'hdeadbeef;
        m_wr_be[4 +: 4] = 4'b0011;
        m_rd_req = 3'b100;
        m_rd_addr[64 +: 32] = 32'h8000;
        @(negedge clk);
        chk("par_s_wr_req", 32'(s_wr_req), 32'h08);
        chk("par_s_rd_req", 32'(s_rd_req), 32'h02);
        chk("par_s3_be", 32'(s_wr_be[12 +: 4]), 32'h3);
        chk("par_s3_data", s_wr_data[96 +: 32], 32'hdeadbeef);
        chk("par_s3_addr", s_wr_addr[96 +: 32], 32'h20010);
        chk("par_s1_addr", s_rd_addr[32 +: 32], 32'h8000);
        chk("par_s0_data_zero", s_wr_data[0 +: 32], 32'h0);
        chk("par_m_wr_gnt", 32'(m_wr_gnt), 32'h2);
        chk("par_m_rd_gnt", 32'(m_rd_gnt), 32'h4);
        next_cycle();
        m_rd_req = '0; m_wr_req = '0;
        set_sdata(6);
        @(negedge clk);
        chk("par_rd_data2", m_rd_data[64 +: 32], sd(1, 6));
        chk("par_rd_data1", m_rd_data[32 +: 32], 32'h0);
        next_cycle();

        // Read and write on one master: the read goes, the write waits.
        m_rd_req = 3'b001; m_rd_addr[0 +: 32] = 32'h10;
        m_wr_req = 3'b001; m_wr_addr[0 +: 32] = 32'h8004;
        @(negedge clk);
        chk("prio_rd_gnt", 32'(m_rd_gnt), 32'h1);
        chk("prio_wr_gnt", 32'(m_wr_gnt), 32'h0);
        chk("prio_s_wr_req", 32'(s_wr_req), 32'h0);
        chk("prio_s_rd_req", 32'(s_rd_req), 32'h01);
        next_cycle();
        m_rd_req = '0; m_wr_req = '0;
        set_sdata(7);
        @(negedge clk);
        chk("prio_rd_data", m_rd_data[0 +: 32], sd(0, 7));
        next_cycle();

        // Undecoded read: local grant, zero data, counter 0 -> 1.
        m_rd_req = 3'b001; m_rd_addr[0 +: 32] = 32'h00040000;
        @(negedge clk);
        chk("derr_gnt", 32'(m_rd_gnt), 32'h1);
        chk("derr_no_slave", 32'(s_rd_req), 32'h0);
        chk("derr_cnt0", 32'(dec_err_cnt), 32'h0);
        next_cycle();
        m_rd_req = '0;
        set_sdata(8);
        @(negedge clk);
        chk("derr_data", m_rd_data[0 +: 32], 32'h0);
        chk("derr_cnt1", 32'(dec_err_cnt), 32'h1);
        next_cycle();

        // Three simultaneous misses add 3 per cycle, then saturate.
        m_rd_req = 3'b101;
        m_rd_addr[0 +: 32]  = 32'h40000;
        m_rd_addr[64 +: 32] = 32'h1000;
        m_wr_req = 3'b010;
        m_wr_addr[32 +: 32] = 32'h50000;
        @(negedge clk);
        chk("derr3_rd_gnt", 32'(m_rd_gnt), 32'h5);
        chk("derr3_wr_gnt", 32'(m_wr_gnt), 32'h2);
        chk("derr3_no_slave", 32'(s_rd_req | s_wr_req), 32'h0);
        next_cycle();
        chk("derr3_cnt4", 32'(dec_err_cnt), 32'h4);
        repeat (21843) @(posedge clk);
        @(negedge clk);
        chk("derr_cnt_fffd", 32'(dec_err_cnt), 32'hfffd);
        repeat (1490) @(posedge clk);
        @(negedge clk);
        chk("derr_cnt_sat", 32'(dec_err_cnt), 32'hffff);
        next_cycle();
        m_rd_req = '0; m_wr_req = '0;
        next_cycle();

        // Slave 1 withholds grant: selection locks on master 1.
        s_rd_gnt = 5'b11101;
        m_rd_req = 3'b010;
        m_rd_addr[32 +: 32] = 32'h8008;
        @(negedge clk);
        chk("lock_s1_req", 32'(s_rd_req[1]), 32'h1);
        chk("lock_addr_h1", s_rd_addr[32 +: 32], 32'h8008);
        next_cycle();
        m_rd_req = 3'b011;
        m_rd_addr[0 +: 32] = 32'h8000;
        for (int h = 2; h <= 5; h++) begin
            @(negedge clk);
            chk($sformatf("lock_addr_h%0d", h), s_rd_addr[32 +: 32], 32'h8008);
            chk($sformatf("lock_gnt_h%0d", h), 32'(m_rd_gnt), 32'h0);
            chk($sformatf("fp_lock_addr_h%0d", h), fp_s_rd_addr[32 +: 32], 32'h8008);
            next_cycle();
        end
        s_rd_gnt = 5'h1f;
        @(negedge clk);
        chk("lock_release_gnt", 32'(m_rd_gnt), 32'h2);
        chk("fp_lock_release_gnt", 32'(fp_m_rd_gnt), 32'h2);
        next_cycle();
        set_sdata(9);
        @(negedge clk);
        chk("rr_after_lock_gnt", 32'(m_rd_gnt), 32'h1);
        chk("fp_after_lock_gnt", 32'(fp_m_rd_gnt), 32'h1);
        chk("lock_rd_data1", m_rd_data[32 +: 32], sd(1, 9));
        chk("rr_after_lock_addr", s_rd_addr[32 +: 32], 32'h8000);
        next_cycle();
        @(negedge clk);
        chk("rr_ptr_moved_gnt", 32'(m_rd_gnt), 32'h2);
        next_cycle();
        m_rd_req = '0;
        next_cycle();

        // Reset the cycle after a read grant: the pending read is dropped.
        m_rd_req = 3'b001; m_rd_addr[0 +: 32] = 32'h10;
        @(negedge clk);
        chk("rstp_gnt", 32'(m_rd_gnt), 32'h1);
        next_cycle();
        rst_n = 1'b0;
        set_sdata(10);
        @(negedge clk);
        chk("rstp_data", m_rd_data[0 +: 32], 32'h0);
        chk("rstp_gnt_off", 32'(m_rd_gnt | m_wr_gnt), 32'h0);
        chk("rstp_s_req", 32'(s_rd_req), 32'h0);
        chk("rstp_cnt", 32'(dec_err_cnt), 32'h0);
        chk("rstp_fp_cnt", 32'(fp_dec_err_cnt), 32'h0);
        next_cycle();
        m_rd_req = '0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstp_after_data", m_rd_data[0 +: 32] | m_rd_data[32 +: 32] | m_rd_data[64 +: 32], 32'h0);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/naive_bus_rr_router.md
NAIVE_BUS_RR_ROUTER -- requirements
Module: naive_bus_rr_router

Interface
REQ-001 SHALL have parameter N_MASTER, default 3, number of bus masters (1..8).
REQ-002 SHALL have parameter N_SLAVE, default 5, number of bus slaves (1..8).
REQ-003 SHALL have parameter SLAVES_MASK, default {32'h3,32'hfff,32'hfff,32'hfff,32'hfff}, packed N_SLAVE*32, slave i in bits [32i+31:32i].
REQ-004 SHALL have parameter SLAVES_BASE, default {32'h30000,32'h20000,32'h10000,32'h8000,32'h0}, same packing.
REQ-005 SHALL have parameter ARB_MODE, default 1, 0 = fixed priority (lowest master index wins), 1 = round-robin.
REQ-006 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have master ports m_rd_req/m_wr_req input N_MASTER, m_rd_gnt/m_wr_gnt output N_MASTER, m_rd_addr/m_wr_addr/m_wr_data input N_MASTER*32, m_wr_be input N_MASTER*4, m_rd_data output N_MASTER*32.
REQ-009 SHALL have slave ports s_rd_req/s_wr_req output N_SLAVE, s_rd_gnt/s_wr_gnt input N_SLAVE, s_rd_addr/s_wr_addr/s_wr_data output N_SLAVE*32, s_wr_be output N_SLAVE*4, s_rd_data input N_SLAVE*32.
REQ-010 SHALL have port dec_err_cnt  output  16  count of undecoded accesses.

Function
REQ-011 SHALL decode a master address to slave i when (addr & ~MASK_i) == BASE_i; if several match, lowest i wins.
REQ-012 SHALL treat m_rd_req as taking precedence over m_wr_req when both are high on one master; that write waits.
REQ-013 SHALL arbitrate independently per slave, so different masters SHALL reach different slaves in the same cycle.
REQ-014 SHALL in round-robin mode search from per-slave pointer ptr_i upward with wrap; ptr_i SHALL become granted index+1 (mod N_MASTER) only on the cycle the slave grants.
REQ-015 SHALL lock the selected master for slave i while its request is asserted and ungranted; the lock SHALL clear on the grant cycle or when that request drops.
REQ-016 SHALL route only the selected master's req/addr/data/be to the slave, and zero the outputs of a slave with no selected master.
REQ-017 SHALL pass s_*_gnt combinationally to the selected master only; all other masters see gnt=0.
REQ-018 SHALL return read data one cycle after grant: a per-master registered pending flag plus slave index SHALL select s_rd_data into m_rd_data on the following cycle.
REQ-019 SHALL drive m_rd_data to 0 on any cycle with no read pending for that master.
REQ-020 SHALL complete an undecoded read or write with gnt=1 in the same cycle, read data 32'h0 next cycle, and no slave access.
REQ-021 SHALL increment dec_err_cnt once per undecoded access, saturating at 16'hffff; simultaneous errors from k masters SHALL add k (saturating).
REQ-022 SHALL support back-to-back reads: a new grant in cycle n+1 SHALL not corrupt data for the grant in cycle n.

Reset
REQ-023 SHALL on rst_n low immediately clear all pointers, locks, read-pending flags and dec_err_cnt, and force m_*_gnt, m_rd_data, s_*_req to 0.
REQ-024 SHALL, when reset asserts with a read pending, discard that read; no data SHALL appear after reset release.

Verification
REQ-025 SHALL cover: masters 0 and 2 read slave 2 (0x10004) continuously, slave always grants, ARB_MODE=1 -> grants alternate 0,2,0,2; each m_rd_data equals slave data one cycle later.
REQ-026 SHALL cover: same stimulus, ARB_MODE=0 -> master 0 granted every cycle, master 2 never.
REQ-027 SHALL cover: master 1 writes 0x20010 be=4'b0011 while master 2 reads 0x8000 -> both slaves accessed in the same cycle, correct be/data on slave 3.
REQ-028 SHALL cover: master 0 reads 0x00040000 -> gnt same cycle, data 0 next cycle, dec_err_cnt 0->1; 70000 errors -> 16'hffff.
REQ-029 SHALL cover: slave 1 withholds gnt 5 cycles with masters 0,1 requesting in RR -> selection locked on first chosen master, pointer moves only on grant.
REQ-030 SHALL cover: rst_n asserted the cycle after a read grant -> m_rd_data stays 0, all gnt 0, counter 0.
